// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the EX/ID/fetch hazard sources and pipe_ctrl.
// master = pipeline side driving hazard requests, slave = the controller.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_jump_flag;
  logic [ADDR_W-1:0] i_jump_addr;
  logic              i_div_start;
  logic              i_div_done;
  logic              i_load_use;
  logic              i_bus_wait;
  logic              o_pc_hold;
  logic              o_pc_jump;
  logic [ADDR_W-1:0] o_pc_jump_addr;
  logic              o_if_id_flush;
  logic              o_if_id_stall;
  logic              o_id_ex_flush;
  logic              o_id_ex_stall;
  logic              o_div_timeout;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport master (
    output i_jump_flag, i_jump_addr, i_div_start, i_div_done, i_load_use, i_bus_wait,
    input  o_pc_hold, o_pc_jump, o_pc_jump_addr, o_if_id_flush, o_if_id_stall,
           o_id_ex_flush, o_id_ex_stall, o_div_timeout, o_stall_cnt
  );

  modport slave (
    input  i_jump_flag, i_jump_addr, i_div_start, i_div_done, i_load_use, i_bus_wait,
    output o_pc_hold, o_pc_jump, o_pc_jump_addr, o_if_id_flush, o_if_id_stall,
           o_id_ex_flush, o_id_ex_stall, o_div_timeout, o_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/flow controller for the 5-stage core: merges jumps, divider occupancy,
// load-use and fetch wait into pc/IF-ID/ID-EX controls plus stall stats and div watchdog.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int DIV_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input logic      i_Clk,
  input logic      i_reset,
  pipe_ctrl_if.slave bus
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(DIV_TIMEOUT);

  typedef enum logic [1:0] {RUN, FLUSH, DIV_WAIT} state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     fcnt, fcnt_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              tmo_nxt, div_timeout;
  logic [CNT_W-1:0]  stall_cnt;
  logic              pc_hold, pc_jump, if_id_flush, if_id_stall, id_ex_flush, id_ex_stall;
  logic [ADDR_W-1:0] pc_jump_addr;

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= RUN;
      fcnt        <= '0;
      tcnt        <= '0;
      div_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      fcnt        <= fcnt_nxt;
      tcnt        <= tcnt_nxt;
      div_timeout <= tmo_nxt;
      if (pc_hold && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    tcnt_nxt     = tcnt;
    tmo_nxt      = 1'b0;
    pc_hold      = 1'b0;
    pc_jump      = 1'b0;
    pc_jump_addr = '0;
    if_id_flush  = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    case (state)
      RUN: begin
        if (bus.i_jump_flag) begin
          pc_jump      = 1'b1;
          pc_jump_addr = bus.i_jump_addr;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
          end
        end else if (bus.i_div_start) begin
          // divide op advances into EX this cycle; the hold starts next cycle
          state_nxt = DIV_WAIT;
          tcnt_nxt  = '0;
        end else if (bus.i_load_use) begin
          pc_hold     = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.i_bus_wait) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (bus.i_jump_flag) begin
          pc_jump      = 1'b1;
          pc_jump_addr = bus.i_jump_addr;
          fcnt_nxt     = FW'(FLUSH_CYCLES - 1);
        end else if (fcnt == FW'(1)) begin
          state_nxt = RUN;
        end else begin
          fcnt_nxt = fcnt - 1'b1;
        end
      end
      DIV_WAIT: begin
        pc_hold     = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        tcnt_nxt    = tcnt + 1'b1;
        if (bus.i_div_done) begin
          state_nxt = RUN;
        end else if (tcnt == TW'(DIV_TIMEOUT - 1)) begin
          state_nxt = RUN;
          tmo_nxt   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // reset drops every control immediately, not just at the next edge
    if (i_reset) begin
      pc_hold      = 1'b0;
      pc_jump      = 1'b0;
      pc_jump_addr = '0;
      if_id_flush  = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      id_ex_stall  = 1'b0;
    end
  end

  assign bus.o_pc_hold      = pc_hold;
  assign bus.o_pc_jump      = pc_jump;
  assign bus.o_pc_jump_addr = pc_jump_addr;
  assign bus.o_if_id_flush  = if_id_flush;
  assign bus.o_if_id_stall  = if_id_stall;
  assign bus.o_id_ex_flush  = id_ex_flush;
  assign bus.o_id_ex_stall  = id_ex_stall;
  assign bus.o_div_timeout  = div_timeout;
  assign bus.o_stall_cnt    = stall_cnt;
endmodule
